// File: rtl/pipeline_pkg.sv
// Shared types and widths for the pipeline hazard sequencer.
// Imported by the stall controller and its mul/div timer.
package pipeline_pkg;

  typedef enum logic {
    RUN,
    MULDIV
  } state_t;

  localparam int MULDIV_CNT_W = 4;
  localparam int STALL_CNT_W  = 32;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(
    input logic [STALL_CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_muldiv_timer.sv
// Load / decrement / freeze counter tracking mul/div occupancy of EX.
// last flags the final MULDIV cycle (cnt==1).
module muldiv_timer
  import pipeline_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [MULDIV_CNT_W-1:0] load_val,
  input  logic                    dec,
  output logic                    last
);

  logic [MULDIV_CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == MULDIV_CNT_W'(1));

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Decodes hazards into register enables, bubbles and flushes.
module pipeline_stall_ctrl
  import pipeline_pkg::*;
#(
  parameter int MULDIV_LAT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ld_hazard,
  input  logic                   redirect,
  input  logic                   muldiv_issue,
  input  logic                   dmem_wait,
  output logic                   pc_we,
  output logic                   ifid_we,
  output logic                   idex_we,
  output logic                   exmem_we,
  output logic                   ifid_flush,
  output logic                   idex_bubble,
  output logic                   exmem_bubble,
  output logic                   memwb_bubble,
  output logic                   muldiv_busy,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam logic LAT_MULTI = (MULDIV_LAT > 1);
  localparam logic [MULDIV_CNT_W-1:0] LAT_M1 =
    MULDIV_CNT_W'(MULDIV_LAT - 1);

  state_t state;
  state_t state_nx;
  logic   tmr_load;
  logic   tmr_dec;
  logic   tmr_last;

  muldiv_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (LAT_M1),
    .dec      (tmr_dec),
    .last     (tmr_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    tmr_load     = 1'b0;
    tmr_dec      = 1'b0;
    pc_we        = 1'b0;
    ifid_we      = 1'b0;
    idex_we      = 1'b0;
    exmem_we     = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    memwb_bubble = 1'b0;
    if (rst) begin
      state_nx = RUN;
    end else if (dmem_wait) begin
      // whole pipe frozen; MEM/WB drains a NOP
      memwb_bubble = 1'b1;
    end else begin
      unique case (state)
        MULDIV: begin
          exmem_we     = 1'b1;
          exmem_bubble = 1'b1;
          tmr_dec      = 1'b1;
          if (tmr_last) state_nx = RUN;
        end
        RUN: begin
          pc_we    = 1'b1;
          ifid_we  = 1'b1;
          idex_we  = 1'b1;
          exmem_we = 1'b1;
          if (redirect) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (ld_hazard) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
          end else if (muldiv_issue && LAT_MULTI) begin
            tmr_load = 1'b1;
            state_nx = MULDIV;
          end
        end
        default: state_nx = RUN;
      endcase
    end
  end

  assign muldiv_busy = (state == MULDIV) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (!pc_we) begin
      stall_cycles <= sat_inc(stall_cycles);
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Randomized bench for pipeline_stall_ctrl at latencies 4, 1 and 8.
// A per-instance occupancy model predicts every control output.
module tb_pipeline_stall_ctrl;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst;
  logic ld;
  logic rd;
  logic is;
  logic dw;

  logic [8:0]  ctl [N];
  logic [31:0] sc  [N];

  int lat [N];
  int busy_left [N];
  longint stalls [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int L = (g == 0) ? 4 : (g == 1) ? 1 : 8;
    pipeline_stall_ctrl #(.MULDIV_LAT(L)) dut (
      .clk          (clk),
      .rst          (rst),
      .ld_hazard    (ld),
      .redirect     (rd),
      .muldiv_issue (is),
      .dmem_wait    (dw),
      .pc_we        (ctl[g][8]),
      .ifid_we      (ctl[g][7]),
      .idex_we      (ctl[g][6]),
      .exmem_we     (ctl[g][5]),
      .ifid_flush   (ctl[g][4]),
      .idex_bubble  (ctl[g][3]),
      .exmem_bubble (ctl[g][2]),
      .memwb_bubble (ctl[g][1]),
      .muldiv_busy  (ctl[g][0]),
      .stall_cycles (sc[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs: {pc,ifid,idex,exmem we, flush, idex/exmem/memwb bubble, busy}
  function automatic logic [8:0] model_ctl(int bl);
    logic [8:0] e;
    e = '0;
    if (rst) return e;
    e[0] = (bl > 0);
    if (dw) begin
      e[1] = 1'b1;
    end else if (bl > 0) begin
      e[5] = 1'b1;
      e[2] = 1'b1;
    end else if (rd) begin
      e[8:5] = 4'hF;
      e[4]   = 1'b1;
      e[3]   = 1'b1;
    end else if (ld) begin
      e[6] = 1'b1;
      e[5] = 1'b1;
      e[3] = 1'b1;
    end else begin
      e[8:5] = 4'hF;
    end
    return e;
  endfunction

  task automatic step(input logic r, input logic l, input logic d,
                      input logic i, input logic w);
    logic [8:0] e;
    @(negedge clk);
    rst = r; ld = l; rd = d; is = i; dw = w;
    #1;
    for (int k = 0; k < N; k++) begin
      if (rst) begin
        busy_left[k] = 0;
        stalls[k]    = 0;
      end
      e = model_ctl(busy_left[k]);
      chk($sformatf("ctl%0d", lat[k]), 32'(ctl[k]), 32'(e));
      chk($sformatf("stall%0d", lat[k]), sc[k],
          (stalls[k] > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(stalls[k]));
      if (!rst) begin
        if (!e[8]) stalls[k]++;
        if (dw) begin
        end else if (busy_left[k] > 0) begin
          busy_left[k]--;
        end else if (!rd && !ld && is && lat[k] > 1) begin
          busy_left[k] = lat[k] - 1;
        end
      end
    end
  endtask

  initial begin
    lat[0] = 4; lat[1] = 1; lat[2] = 8;
    for (int k = 0; k < N; k++) begin
      busy_left[k] = 0;
      stalls[k]    = 0;
    end
    rst = 1'b1; ld = 1'b0; rd = 1'b0; is = 1'b0; dw = 1'b0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // load-use single stall
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // mul/div issue, then run out
    step(0, 0, 0, 1, 0);
    for (int c = 0; c < 9; c++) step(0, 0, 0, 0, 0);
    // mul/div with dmem_wait at T+2 for two cycles
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    for (int c = 0; c < 9; c++) step(0, 0, 0, 0, 0);
    // redirect overrides load-use and mul/div
    step(0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0);
    // reset in the middle of a long operation
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int c = 0; c < 4000; c++) begin
      step(($urandom_range(99) < 2),
           ($urandom_range(99) < 20),
           ($urandom_range(99) < 15),
           ($urandom_range(99) < 25),
           ($urandom_range(99) < 20));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
